// File: rtl/vga_sprite_engine_pkg.sv
// vga_sprite_pkg: shared types and constants for the sprite engine.
//   state_t     - update FSM states
//   OBJ_COLOUR  - fixed 24-bit colour per sprite index (RGB, 8 bits each)
//   ORG_*/STEP_* - reset origin and per-index spacing of the sprites
//   axis_step   - one-axis move with edge bounce, returns {dir, pos}
package vga_sprite_pkg;

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  localparam logic [23:0] OBJ_COLOUR [0:5] = '{
    24'hFFFFFF, 24'h0000FF, 24'hFF0000, 24'h00FF00, 24'hFFFF00, 24'h00FFFF
  };

  localparam int ORG_X  = 40;
  localparam int STEP_X = 80;
  localparam int ORG_Y  = 40;
  localparam int STEP_Y = 60;

  // Moves pos by spd toward dir (1 = increasing) and clamps into 0..lim,
  // flipping the direction on contact. 11-bit sums so pos+spd never wraps.
  function automatic logic [10:0] axis_step(input logic [9:0]  pos,
                                            input logic        dir,
                                            input logic [10:0] spd,
                                            input logic [10:0] lim);
    logic [10:0] p;
    p = {1'b0, pos};
    if (dir) begin
      if (p + spd >= lim) return {1'b0, lim[9:0]};
      else                return {1'b1, p[9:0] + spd[9:0]};
    end else begin
      if (p <= spd) return {1'b1, 10'd0};
      else          return {1'b0, p[9:0] - spd[9:0]};
    end
  endfunction

endpackage

// File: rtl/vga_sprite_engine_sprite_hit.sv
// sprite_hit: combinational coverage test of one square sprite.
//   obj_x_i/obj_y_i  sprite top-left corner
//   pix_x_i/pix_y_i  current pixel coordinate
//   en_i             draw enable for this sprite
//   hit_o            1 when the pixel lies inside the sprite and en_i=1
module sprite_hit #(
  parameter int OBJ_SIZE = 40
) (
  input  logic [9:0] obj_x_i,
  input  logic [9:0] obj_y_i,
  input  logic [9:0] pix_x_i,
  input  logic [9:0] pix_y_i,
  input  logic       en_i,
  output logic       hit_o
);

  logic [10:0] x_end, y_end;

  assign x_end = {1'b0, obj_x_i} + 11'(OBJ_SIZE);
  assign y_end = {1'b0, obj_y_i} + 11'(OBJ_SIZE);

  assign hit_o = en_i &&
                 (pix_x_i >= obj_x_i) && ({1'b0, pix_x_i} < x_end) &&
                 (pix_y_i >= obj_y_i) && ({1'b0, pix_y_i} < y_end);

endmodule

// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: bouncing-square sprite renderer for the VGA controller.
//   CLOCK_50_I, resetn        clock, async active-low reset
//   enable                    pixel strobe; colour register loads when 1
//   pixel_X_pos/pixel_Y_pos   current coordinate from VGA_controller
//   vga_vsync_n               frame boundary; falling edge triggers motion
//   obj_enable[NUM_OBJ]       per-sprite draw enable
//   pause                     freezes motion (rendering unaffected)
//   VGA_red/green/blue        registered pixel colour
//   update_busy               high while the update FSM is not idle
module vga_sprite_engine
  import vga_sprite_pkg::*;
#(
  parameter int NUM_OBJ  = 4,
  parameter int OBJ_SIZE = 40,
  parameter int SPEED    = 2,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480
) (
  input  logic               CLOCK_50_I,
  input  logic               resetn,
  input  logic               enable,
  input  logic [9:0]         pixel_X_pos,
  input  logic [9:0]         pixel_Y_pos,
  input  logic               vga_vsync_n,
  input  logic [NUM_OBJ-1:0] obj_enable,
  input  logic               pause,
  output logic [7:0]         VGA_red,
  output logic [7:0]         VGA_green,
  output logic [7:0]         VGA_blue,
  output logic               update_busy
);

  localparam logic [10:0] XM  = 11'(H_RES - OBJ_SIZE);
  localparam logic [10:0] YM  = 11'(V_RES - OBJ_SIZE);
  localparam logic [10:0] SPD = 11'(SPEED);

  state_t                   state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  logic                     vsync_q, tick, upd_en;
  logic [NUM_OBJ-1:0][9:0]  x_q, x_d, y_q, y_d;
  logic [NUM_OBJ-1:0]       dx_q, dx_d, dy_q, dy_d;
  logic [NUM_OBJ-1:0]       hit;
  logic [23:0]              colour_q, colour_d;

  // Falling edge of VSYNC: previous sample high, live input low.
  assign tick = vsync_q & ~vga_vsync_n;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    upd_en  = 1'b0;
    unique case (state_q)
      S_IDLE: if (tick && !pause) begin
        idx_d   = 3'd0;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        upd_en = 1'b1;
        idx_d  = idx_q + 3'd1;
        if (idx_q == 3'(NUM_OBJ - 1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only the sprite selected by idx moves on a given update cycle.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (upd_en) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (idx_q == 3'(i)) begin
          {dx_d[i], x_d[i]} = axis_step(x_q[i], dx_q[i], SPD, XM);
          {dy_d[i], y_d[i]} = axis_step(y_q[i], dy_q[i], SPD, YM);
        end
      end
    end
  end

  // Lowest index wins: scan high to low so lower indices overwrite.
  always_comb begin
    colour_d = 24'h000000;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit[i]) colour_d = OBJ_COLOUR[i];
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      vsync_q  <= 1'b1;
      colour_q <= 24'h000000;
      for (int i = 0; i < NUM_OBJ; i++) begin
        x_q[i]  <= 10'(ORG_X + STEP_X * i);
        y_q[i]  <= 10'(ORG_Y + STEP_Y * i);
        dx_q[i] <= 1'((i + 1) % 2);
        dy_q[i] <= 1'b1;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vsync_q <= vga_vsync_n;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      if (enable) colour_q <= colour_d;
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
    sprite_hit #(.OBJ_SIZE(OBJ_SIZE)) u_hit (
      .obj_x_i (x_q[g]),
      .obj_y_i (y_q[g]),
      .pix_x_i (pixel_X_pos),
      .pix_y_i (pixel_Y_pos),
      .en_i    (obj_enable[g]),
      .hit_o   (hit[g])
    );
  end

  assign update_busy = (state_q != S_IDLE);
  assign VGA_red     = colour_q[23:16];
  assign VGA_green   = colour_q[15:8];
  assign VGA_blue    = colour_q[7:0];

endmodule
